sens_crc_frame: RTL and testbench
=================================

SENS_CRC_FRAME -- requirements
Module: sens_crc_frame

Interface
REQ-001 SHALL have parameter DATA_W, default 8: input word width; allowed values are 8, 16 or 32.
REQ-002 SHALL have parameter CRC_W, default 8: CRC width; allowed values are 8 or 16; CRC_W <= DATA_W.
REQ-003 SHALL have parameter POLY, default 8'h31: generator polynomial with the implicit top bit omitted (x^8+x^5+x^4+1).
REQ-004 SHALL have parameter INIT, default 0: CRC register start value for each frame.
REQ-005 SHALL have parameter NWORDS, default 2: data words per frame, range 1..255.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on posedge.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port d_valid, input, 1 bit: d carries a word this cycle.
REQ-009 SHALL have port sof, input, 1 bit: qualifies the first data word of a frame; ignored unless d_valid=1.
REQ-010 SHALL have port d, input, DATA_W bits: data word, or received CRC in the final word.
REQ-011 SHALL have port crc_out, output, CRC_W bits: running CRC register.
REQ-012 SHALL have port busy, output, 1 bit: frame in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle frame-complete pulse.
REQ-014 SHALL have port crc_ok, output, 1 bit: result of the last completed frame, held until the next done.
REQ-015 SHALL have port err_cnt, output, 8 bits: count of mismatched frames.

Function
REQ-016 SHALL implement a non-reflected CRC, MSB first, processing a whole DATA_W word per accepted cycle (no final XOR).
REQ-017 SHALL implement a state machine with states IDLE, DATA, CHK.
- IDLE: d_valid&sof loads crc_reg with f(INIT,d), sets word count to 1, then goes to CHK if NWORDS=1, else to DATA.
- IDLE: d_valid without sof is ignored.
REQ-018 SHALL, in DATA, on each d_valid, set crc_reg=f(crc_reg,d) and increment the count; go to CHK when the count reaches NWORDS; cycles with d_valid=0 hold all state.
REQ-019 SHALL, in CHK, on d_valid, compare d[CRC_W-1:0] with crc_reg, then set done=1 for exactly the next cycle, update crc_ok, and return to IDLE; crc_reg is not updated by the CRC word.
REQ-020 SHALL keep done latency at 1 cycle after the cycle the CRC word is accepted.
REQ-021 SHALL, when d_valid&sof occurs in DATA or CHK, abandon the current frame (no done, no crc_ok or err_cnt change) and treat that word as the first word of a new frame, as from IDLE.
REQ-022 SHALL drive busy=1 in DATA and CHK, and 0 in IDLE.
REQ-023 SHALL, when NWORDS=1, go directly from IDLE to CHK.
REQ-024 SHALL, with a CRC word accepted the same cycle as sof from IDLE, treat sof as taking priority: the word is data.

Reset
REQ-025 SHALL, on rst assertion, asynchronously force state=IDLE, crc_out=INIT, count=0, busy=0, done=0, crc_ok=0, err_cnt=0.
REQ-026 SHALL, on reset mid-frame, discard the frame with no done pulse; the first sof after rst deassertion starts a fresh frame.

Configuration
REQ-027 SHALL use macro SENS_CRC_ERRCNT_EN to select error counting.
- Defined: err_cnt increments on each done with crc_ok=0 and saturates at 255.
- Not defined: err_cnt is constant 0 and has no counter flops.

Verification
REQ-028 SHALL cover: defaults, NWORDS=1, words 0x01 (sof), 0x31 -> done one cycle after 0x31, crc_ok=1, crc_out=0x31.
REQ-029 SHALL cover: INIT=8'hFF, words 0xBE(sof), 0xEF, 0x92 -> crc_out=0x92 after 0xEF, done, crc_ok=1; repeat with 0x93 -> crc_ok=0, err_cnt=1 (with macro) or 0 (without).
REQ-030 SHALL cover: 0xBE(sof), gap of 3 idle cycles, 0xEF, 0x92 -> same result as the no-gap case; busy=1 throughout.
REQ-031 SHALL cover: 0xBE(sof), then 0x12 with sof -> no done; the frame restarts and 0x12 is CRC'd from INIT.
REQ-032 SHALL cover: rst pulse asynchronously between clock edges while in DATA -> immediate IDLE, crc_out=INIT, busy=0, no done.
REQ-033 SHALL cover: 256 mismatching frames with macro defined -> err_cnt stays at 255.

Source files
------------

// File: rtl/sens_crc_frame.sv
// Framed CRC checker: running MSB-first CRC over NWORDS data words, then compares it with a trailing CRC word.
// Define SENS_CRC_ERRCNT_EN to build the saturating mismatch counter on err_cnt.
module sens_crc_frame #(
    parameter int               DATA_W = 8,
    parameter int               CRC_W  = 8,
    parameter logic [CRC_W-1:0] POLY   = 8'h31,
    parameter logic [CRC_W-1:0] INIT   = '0,
    parameter int               NWORDS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_valid,
    input  logic              sof,
    input  logic [DATA_W-1:0] d,
    output logic [CRC_W-1:0]  crc_out,
    output logic              busy,
    output logic              done,
    output logic              crc_ok,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {IDLE, DATA, CHK} state_t;

    localparam logic [7:0] NW = 8'(NWORDS);

    state_t           state;
    logic [7:0]       cnt;
    logic [7:0]       cnt_nxt;
    logic [CRC_W-1:0] crc_reg;
    logic             start;
    logic             chk_acc;
    logic             match;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                  input logic [DATA_W-1:0] w);
        logic [CRC_W-1:0] r;
        logic             fb;
        r = c;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = r[CRC_W-1] ^ w[i];
            r  = {r[CRC_W-2:0], 1'b0};
            if (fb) r = r ^ POLY;
        end
        return r;
    endfunction

    // sof always wins: it restarts a frame from any state, even over a pending CRC word
    assign start   = d_valid && sof;
    assign chk_acc = d_valid && !sof && (state == CHK);
    assign match   = (d[CRC_W-1:0] == crc_reg);
    assign cnt_nxt = cnt + 8'd1;
    assign crc_out = crc_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            crc_reg <= INIT;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            crc_ok  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                crc_reg <= crc_step(INIT, d);
                cnt     <= 8'd1;
                busy    <= 1'b1;
                state   <= (NWORDS == 1) ? CHK : DATA;
            end else if (d_valid) begin
                case (state)
                    DATA: begin
                        crc_reg <= crc_step(crc_reg, d);
                        cnt     <= cnt_nxt;
                        if (cnt_nxt == NW) state <= CHK;
                    end
                    CHK: begin
                        done   <= 1'b1;
                        crc_ok <= match;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SENS_CRC_ERRCNT_EN
    logic [7:0] err_q;

    // bumps on the same edge that raises done, so err_cnt and done/crc_ok agree
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (chk_acc && !match && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    logic unused_chk;
    assign unused_chk = chk_acc;
    assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_sens_crc_frame.sv
// Directed bench: table of per-cycle vectors on a two-word INIT=FF instance plus a one-word instance.
module tb_sens_crc_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic       v, s;
    logic [7:0] dd;
    logic [7:0] crc;
    logic       busy, done, ok;
    logic [7:0] err;
    logic       v1, s1;
    logic [7:0] dd1;
    logic [7:0] crc1;
    logic       busy1, done1, ok1;
    logic [7:0] err1;

    int checks   = 0;
    int failures = 0;

`ifdef SENS_CRC_ERRCNT_EN
    localparam logic [7:0] E = 8'd1;
`else
    localparam logic [7:0] E = 8'd0;
`endif

    always #5 clk = ~clk;

    sens_crc_frame #(.DATA_W(8), .CRC_W(8), .POLY(8'h31), .INIT(8'hFF), .NWORDS(2)) dut (
        .clk(clk), .rst(rst), .d_valid(v), .sof(s), .d(dd),
        .crc_out(crc), .busy(busy), .done(done), .crc_ok(ok), .err_cnt(err)
    );

    sens_crc_frame #(.DATA_W(8), .CRC_W(8), .POLY(8'h31), .INIT(8'h00), .NWORDS(1)) dut1 (
        .clk(clk), .rst(rst), .d_valid(v1), .sof(s1), .d(dd1),
        .crc_out(crc1), .busy(busy1), .done(done1), .crc_ok(ok1), .err_cnt(err1)
    );

    typedef struct {
        logic       v;
        logic       s;
        logic [7:0] d;
        logic [7:0] crc;
        logic       busy;
        logic       done;
        logic       ok;
        logic [7:0] err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic is, input logic [7:0] id,
                       input logic [7:0] ecrc, input logic ebusy, input logic edone,
                       input logic eok, input logic [7:0] eerr);
        vec_t t;
        t = '{v: iv, s: is, d: id, crc: ecrc, busy: ebusy, done: edone, ok: eok, err: eerr};
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic is, input logic [7:0] id);
        v = iv; s = is; dd = id;
        tick();
    endtask

    task automatic bad_frame();
        drive(1'b1, 1'b1, 8'hBE);
        drive(1'b1, 1'b0, 8'hEF);
        drive(1'b1, 1'b0, 8'h93);
    endtask

    initial begin
        rst = 1'b1; v = 0; s = 0; dd = 0; v1 = 0; s1 = 0; dd1 = 0;

        // idle and ignored non-sof word
        add(0,0,8'h00, 8'hFF,0,0,0,0);
        add(1,0,8'h55, 8'hFF,0,0,0,0);
        // good frame BE EF / 92
        add(1,1,8'hBE, 8'h0C,1,0,0,0);
        add(1,0,8'hEF, 8'h92,1,0,0,0);
        add(1,0,8'h92, 8'h92,0,1,1,0);
        add(0,0,8'h00, 8'h92,0,0,1,0);
        // same frame with a 3-cycle gap
        add(1,1,8'hBE, 8'h0C,1,0,1,0);
        add(0,0,8'h00, 8'h0C,1,0,1,0);
        add(0,0,8'h00, 8'h0C,1,0,1,0);
        add(0,0,8'h00, 8'h0C,1,0,1,0);
        add(1,0,8'hEF, 8'h92,1,0,1,0);
        add(0,0,8'h00, 8'h92,1,0,1,0);
        add(1,0,8'h92, 8'h92,0,1,1,0);
        // mismatching CRC word
        add(1,1,8'hBE, 8'h0C,1,0,1,0);
        add(1,0,8'hEF, 8'h92,1,0,1,0);
        add(1,0,8'h93, 8'h92,0,1,0,E);
        add(0,0,8'h00, 8'h92,0,0,0,E);
        // sof in DATA restarts from INIT: f(FF,12)=8D
        add(1,1,8'hBE, 8'h0C,1,0,0,E);
        add(1,1,8'h12, 8'h8D,1,0,0,E);
        add(0,0,8'h00, 8'h8D,1,0,0,E);
        // sof in CHK restarts, then a good frame completes
        add(1,1,8'hBE, 8'h0C,1,0,0,E);
        add(1,0,8'hEF, 8'h92,1,0,0,E);
        add(1,1,8'hBE, 8'h0C,1,0,0,E);
        add(1,0,8'hEF, 8'h92,1,0,0,E);
        add(1,0,8'h92, 8'h92,0,1,1,E);
        add(0,0,8'h00, 8'h92,0,0,1,E);
        add(1,0,8'h92, 8'h92,0,0,1,E);

        #12;
        chk("rst_crc", crc, 8'hFF);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ok", ok, 0);
        chk("rst_err", err, 0);
        chk("rst_crc1", crc1, 8'h00);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].s, vecs[i].d);
            chk($sformatf("v%0d_crc", i), crc, vecs[i].crc);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("v%0d_done", i), done, vecs[i].done);
            chk($sformatf("v%0d_ok", i), ok, vecs[i].ok);
            chk($sformatf("v%0d_err", i), err, vecs[i].err);
        end
        v = 0; s = 0; dd = 0;

        // async reset between edges while in DATA
        drive(1'b1, 1'b1, 8'hBE);
        v = 0; s = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_crc", crc, 8'hFF);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        drive(1'b1, 1'b0, 8'hEF);
        chk("post_rst_nosof", busy, 0);
        drive(1'b1, 1'b1, 8'hBE);
        drive(1'b1, 1'b0, 8'hEF);
        drive(1'b1, 1'b0, 8'h92);
        chk("fresh_done", done, 1);
        chk("fresh_ok", ok, 1);
        v = 0; s = 0;

        // one-word frames: f(00,01)=31
        v1 = 1; s1 = 1; dd1 = 8'h01;
        tick();
        chk("nw1_crc", crc1, 8'h31);
        chk("nw1_busy", busy1, 1);
        chk("nw1_done0", done1, 0);
        s1 = 0; dd1 = 8'h31;
        tick();
        chk("nw1_done", done1, 1);
        chk("nw1_ok", ok1, 1);
        chk("nw1_crc_hold", crc1, 8'h31);
        chk("nw1_idle", busy1, 0);
        s1 = 1; dd1 = 8'h01;
        tick();
        s1 = 1; dd1 = 8'h01;
        tick();
        chk("nw1_restart_done", done1, 0);
        chk("nw1_restart_busy", busy1, 1);
        s1 = 0; dd1 = 8'h30;
        tick();
        chk("nw1_bad_done", done1, 1);
        chk("nw1_bad_ok", ok1, 0);
        chk("nw1_bad_err", err1, E);
        v1 = 0; s1 = 0; dd1 = 0;
        tick();
        chk("nw1_done_pulse", done1, 0);

`ifdef SENS_CRC_ERRCNT_EN
        for (int k = 0; k < 256; k++) begin
            bad_frame();
            if (k == 0) chk("err_first", err, 8'd1);
            if (k == 253) chk("err_reach", err, 8'd254);
        end
        chk("err_sat", err, 8'd255);
        chk("err_sat_ok", ok, 0);
`else
        for (int k = 0; k < 3; k++) bad_frame();
        chk("err_off", err, 8'd0);
        chk("err_off_ok", ok, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
